fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of prefetch-buffer entries (power of two, 2..16).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port a  output  32  byte address to the instruction memory; always word aligned, a[1:0]=2'b00.
REQ-006 SHALL have port rd  input  32  instruction word returned combinationally by the instruction memory for a in the same cycle.
REQ-007 SHALL have port br_taken  input  1  redirect request from the execute stage.
REQ-008 SHALL have port br_target  input  32  redirect byte address; bits [1:0] ignored.
REQ-009 SHALL have port instr  output  32  instruction at the buffer head.
REQ-010 SHALL have port pc  output  32  byte address of instr.
REQ-011 SHALL have port valid  output  1  instr/pc hold a fetched instruction.
REQ-012 SHALL have port ready  input  1  decode accepts the head entry when valid and ready are both high.

Function
REQ-013 SHALL hold a fetch pointer fpc; a=fpc every cycle.
REQ-014 A fetch SHALL occur in a cycle when no redirect is present, fetching is not halted, and the buffer count < DEPTH or a pop occurs in the same cycle.
REQ-015 On a fetch, {rd, fpc} SHALL be written at the tail and fpc SHALL advance by 4, wrapping from 32'hFFFF_FFFC to 32'h0.
REQ-016 Fetch-to-valid latency SHALL be exactly 1 cycle; there is no combinational bypass from rd to instr.
REQ-017 A pop (valid && ready) SHALL remove the head; instr and pc SHALL update on the next edge.
REQ-018 A pop and a fetch in the same cycle SHALL leave count unchanged.
REQ-019 With count==DEPTH and no pop, fpc and buffer contents SHALL hold.
REQ-020 With valid low, ready SHALL have no effect.
REQ-021 br_taken=1 SHALL flush all entries and set fpc={br_target[31:2],2'b00} at the edge; valid SHALL be 0 in the following cycle and the target instruction SHALL be valid one cycle after that.
REQ-022 A redirect SHALL take priority over a simultaneous pop or fetch; the popped head counts as consumed, and no fetch occurs that cycle.
REQ-023 The pointer/count arithmetic SHALL use log2(DEPTH)-bit wrap-around indices plus a (log2(DEPTH)+1)-bit count.

Reset
REQ-024 While rst=0 at an edge: fpc=RESET_PC, count=0, pointers=0, halt flag cleared.
REQ-025 During reset: valid=0, a=RESET_PC, instr=32'h0, pc=RESET_PC.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries with no pop visible afterward.
REQ-027 The first fetch SHALL occur in the first cycle with rst=1.

Configuration
REQ-028 Macro FETCH_HALT_ON_ZERO_EN, when defined, SHALL make a fetched word of 32'h0 set a halt flag after it is enqueued.
REQ-029 With FETCH_HALT_ON_ZERO_EN defined, the halt flag SHALL stop further fetches until a redirect or reset clears it.
REQ-030 With FETCH_HALT_ON_ZERO_EN undefined, zero words SHALL be fetched like any other word and no halt flag SHALL exist.

Structure
REQ-031 Package fetch_pkg SHALL hold typedef word_t (32 bits), typedef fetch_entry_t {word_t instr; word_t pc;}, and the constant RESET_PC_DEFAULT.
REQ-032 The buffer SHALL be sub-module fetch_fifo (parameter DEPTH, push, pop, flush, full, empty, head data); fetch_unit SHALL own fpc, fetch control and halt logic.

Verification
REQ-033 Reset then ready=1, with rd at mem[0..3]=A,B,C,D: valid rises at cycle 1; pc=0,4,8,C and instr=A,B,C,D on consecutive cycles.
REQ-034 ready=0 for 10 cycles with DEPTH=4: exactly 4 fetches occur and a holds at 32'h10; then ready=1 gives pc 0,4,8,C,10 in order with no duplicates or gaps.
REQ-035 br_taken=1 with br_target=32'h23 while 3 entries are buffered: the next cycle has valid=0 and a=32'h20; the cycle after has pc=32'h20.
REQ-036 Redirect asserted in the same cycle as a pop: only the target stream appears afterwards; count resets to 0.
REQ-037 With FETCH_HALT_ON_ZERO_EN defined and mem[0x24]=0: fetching stops after 0x24 and a stays at 32'h28; br_target=0 resumes fetching from 0. With the macro undefined: a advances past 32'h28.
REQ-038 rst=0 for one cycle while the buffer is full: valid=0 the next cycle; then the stream restarts at pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t PC_STEP          = 32'h0000_0004;

    // Instruction memory is word addressed; the low two address bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of {instr, pc} with a flush
// that empties it in one edge. Flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_EMPTY = (AW+1)'(0);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Next pointer and occupancy values.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are harmless because occupancy gates them.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == CNT_EMPTY);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch pointer, prefetch control and redirect.
// Optional FETCH_HALT_ON_ZERO_EN stops fetching after a zero word is enqueued.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] a,
    input  logic [31:0] rd,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid,
    input  logic        ready
);

    localparam word_t START_PC = align_word(RESET_PC);

    word_t        fpc_q, fpc_d;
    logic         fetch_s, pop_s, full_s, empty_s;
    fetch_entry_t head_s, push_data_s;

`ifdef FETCH_HALT_ON_ZERO_EN
    logic halt_q, halt_d;
`endif

    // Fetch/pop decision and next fetch pointer; a redirect overrides both.
    always_comb begin
        pop_s = !empty_s && ready;
`ifdef FETCH_HALT_ON_ZERO_EN
        fetch_s = !br_taken && !halt_q && (!full_s || pop_s);
`else
        fetch_s = !br_taken && (!full_s || pop_s);
`endif
        if (br_taken) begin
            fpc_d = align_word(br_target);
        end else if (fetch_s) begin
            fpc_d = fpc_q + PC_STEP;
        end else begin
            fpc_d = fpc_q;
        end
    end

    // Fetch pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc_q <= START_PC;
        end else begin
            fpc_q <= fpc_d;
        end
    end

`ifdef FETCH_HALT_ON_ZERO_EN
    // Halt is raised by the zero word itself, so that word still reaches decode.
    always_comb begin
        if (br_taken) begin
            halt_d = 1'b0;
        end else if (fetch_s && (rd == 32'h0000_0000)) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end
    end

    // Halt flag register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    assign push_data_s = '{instr: rd, pc: fpc_q};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fetch_s),
        .pop_i   (pop_s && !br_taken),
        .flush_i (br_taken),
        .data_i  (push_data_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign a     = fpc_q;
    assign valid = !empty_s;
    assign instr = empty_s ? 32'h0000_0000 : head_s.instr;
    assign pc    = empty_s ? START_PC : head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=4, RESET_PC=0).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] rd;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory image: word at 0x24 is zero, everything else is tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0024) begin
            return 32'h0000_0000;
        end else begin
            return {16'hC0DE, addr[15:0]};
        end
    endfunction

    assign rd = mem_word(a);

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .rd        (rd),
        .br_taken  (br_taken),
        .br_target (br_target),
        .instr     (instr),
        .pc        (pc),
        .valid     (valid),
        .ready     (ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        br_taken = 1'b0;
        step(1);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        ready     = 1'b1;

        // Reset values, then streaming with ready=1
        step(2);
        check_eq("rst_valid", {31'h0, valid}, 32'h0);
        check_eq("rst_a", a, 32'h0000_0000);
        check_eq("rst_instr", instr, 32'h0000_0000);
        check_eq("rst_pc", pc, 32'h0000_0000);
        rst = 1'b1;
        step(1);
        check_eq("c1_valid", {31'h0, valid}, 32'h1);
        check_eq("c1_pc", pc, 32'h0000_0000);
        check_eq("c1_instr", instr, 32'hC0DE_0000);
        for (int k = 1; k < 4; k++) begin
            step(1);
            check_eq("stream_pc", pc, 32'(4 * k));
            check_eq("stream_instr", instr, 32'hC0DE_0000 | 32'(4 * k));
        end

        // Back-pressure: buffer fills at 4 entries, then drains in order
        ready = 1'b0;
        do_reset();
        step(10);
        check_eq("full_a", a, 32'h0000_0010);
        check_eq("full_valid", {31'h0, valid}, 32'h1);
        check_eq("full_pc", pc, 32'h0000_0000);
        ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step(1);
            check_eq("drain_pc", pc, 32'(4 * k));
            check_eq("drain_instr", instr, 32'hC0DE_0000 | 32'(4 * k));
        end

        // Redirect to an unaligned target with 3 entries buffered
        ready = 1'b0;
        do_reset();
        step(3);
        check_eq("three_a", a, 32'h0000_000C);
        br_taken  = 1'b1;
        br_target = 32'h0000_0023;
        step(1);
        br_taken = 1'b0;
        check_eq("redir_valid", {31'h0, valid}, 32'h0);
        check_eq("redir_a", a, 32'h0000_0020);
        step(1);
        check_eq("redir_tvalid", {31'h0, valid}, 32'h1);
        check_eq("redir_pc", pc, 32'h0000_0020);
        check_eq("redir_instr", instr, 32'hC0DE_0020);

        // Redirect coinciding with a pop; only the target stream follows
        ready = 1'b1;
        do_reset();
        step(3);
        check_eq("pre_pop_pc", pc, 32'h0000_0008);
        br_taken  = 1'b1;
        br_target = 32'h0000_0040;
        step(1);
        br_taken = 1'b0;
        check_eq("rpop_valid", {31'h0, valid}, 32'h0);
        check_eq("rpop_a", a, 32'h0000_0040);
        step(1);
        check_eq("rpop_pc0", pc, 32'h0000_0040);
        step(1);
        check_eq("rpop_pc1", pc, 32'h0000_0044);
        ready = 1'b0;
        step(6);
        check_eq("rpop_fill_a", a, 32'h0000_0054);
        check_eq("rpop_hold_pc", pc, 32'h0000_0044);

        // Fetch pointer wrap from the top of the address space
        do_reset();
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFE;
        step(1);
        br_taken = 1'b0;
        check_eq("wrap_a0", a, 32'hFFFF_FFFC);
        step(1);
        check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr", instr, 32'hC0DE_FFFC);
        check_eq("wrap_a1", a, 32'h0000_0000);
        step(1);
        check_eq("wrap_a2", a, 32'h0000_0004);

        // Reset pulse while the buffer is full
        step(3);
        check_eq("pre_rst_a", a, 32'h0000_000C);
        rst = 1'b0;
        step(1);
        check_eq("mid_rst_valid", {31'h0, valid}, 32'h0);
        check_eq("mid_rst_a", a, 32'h0000_0000);
        check_eq("mid_rst_instr", instr, 32'h0000_0000);
        rst = 1'b1;
        step(1);
        check_eq("post_rst_valid", {31'h0, valid}, 32'h1);
        check_eq("post_rst_pc", pc, 32'h0000_0000);

        // Zero word at 0x24: halts only when the feature is built in
        ready = 1'b1;
        do_reset();
        step(10);
        check_eq("zero_pc", pc, 32'h0000_0024);
        check_eq("zero_instr", instr, 32'h0000_0000);
        step(5);
`ifdef FETCH_HALT_ON_ZERO_EN
        check_eq("halt_a", a, 32'h0000_0028);
        check_eq("halt_valid", {31'h0, valid}, 32'h0);
`else
        check_eq("nohalt_a", a, 32'h0000_003C);
        check_eq("nohalt_pc", pc, 32'h0000_0038);
`endif
        br_taken  = 1'b1;
        br_target = 32'h0000_0000;
        step(1);
        br_taken = 1'b0;
        check_eq("resume_a", a, 32'h0000_0000);
        step(1);
        check_eq("resume_valid", {31'h0, valid}, 32'h1);
        check_eq("resume_pc", pc, 32'h0000_0000);
        step(1);
        check_eq("resume_pc1", pc, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
